// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-pipeline types: widths, PC increment and the buffered entry
// layout (byte PC plus instruction word).
package pipeline_pkg;

  localparam int IFQ_DATA_SIZE = 32;
  localparam int IFQ_ADDR_SIZE = 10;
  localparam int IFQ_PC_W      = IFQ_ADDR_SIZE + 2;
  localparam int PC_STEP       = 4;

  typedef struct packed {
    logic [IFQ_PC_W-1:0]      pc;
    logic [IFQ_DATA_SIZE-1:0] inst;
  } fetch_entry_t;

  // Byte PCs are word aligned; the low two bits of a redirect target are dropped.
  function automatic logic [IFQ_PC_W-1:0] align_pc(input logic [IFQ_PC_W-1:0] pc);
    return {pc[IFQ_PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: redirect input, registered ROM port and the decode handshake.
// master = fetch queue, slave = surrounding core / ROM.
interface instr_fetch_queue_if
  import pipeline_pkg::*;
#(
  parameter int DATA_SIZE = IFQ_DATA_SIZE,
  parameter int ADDR_SIZE = IFQ_ADDR_SIZE
);

  logic                 flush;
  logic [ADDR_SIZE+1:0] redirect_pc;
  logic                 rom_req;
  logic [ADDR_SIZE-1:0] rom_addr;
  logic [DATA_SIZE-1:0] rom_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_inst;
  logic [ADDR_SIZE+1:0] out_pc;

  modport master (
    input  flush, redirect_pc, rom_data, out_ready,
    output rom_req, rom_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output flush, redirect_pc, rom_data, out_ready,
    input  rom_req, rom_addr, out_valid, out_inst, out_pc
  );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers, synchronous clear and async reset.
// The read port shows the stored head entry, or zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (count == (AW+1)'(DEPTH));
    do_push  = push && !full && !clr;
    do_pop   = pop && !empty && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty pointer pair.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues ROM reads under a FIFO credit limit,
// buffers returned words with their PCs and redirects/discards on flush.
module instr_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DATA_SIZE = IFQ_DATA_SIZE,
  parameter int ADDR_SIZE = IFQ_ADDR_SIZE,
  parameter int DEPTH     = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  instr_fetch_queue_if.master bus
);

  localparam int PW = ADDR_SIZE + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] req_pc_q, req_pc_d;
  logic          pending_q, pending_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  rd_entry;

  // Credit counts both stored words and the one in flight; a same-cycle pop
  // is deliberately not counted so the issue path never depends on out_ready.
  // rom_req is held low while RESET_N is asserted.
  always_comb begin
    credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
    issue         = RESET_N && !bus.flush && (credit_used < (CW+1)'(DEPTH));
    push          = pending_q && !bus.flush;
    pop           = !fifo_empty && bus.out_ready;
    wr_entry.pc   = req_pc_q;
    wr_entry.inst = bus.rom_data;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pending_d  = issue;
    if (bus.flush) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      pending_d  = 1'b0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PW'(PC_STEP);
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (bus.flush),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.rom_req   = issue;
  assign bus.rom_addr  = fetch_pc_q[PW-1:2];
  assign bus.out_valid = !fifo_empty;
  assign bus.out_inst  = rd_entry.inst;
  assign bus.out_pc    = rd_entry.pc;

endmodule
